// File: rtl/module_ram_responder_if.sv
// CPU-to-RAM four-phase memory handshake: request side (operation/address/data_in) and completion side (data_out/done).
// With RAM_VALID_MASK_EN defined the bundle also carries the per-word valid mask and the GET miss flag.
interface module_ram_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [1:0]        operation;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              done;
`ifdef RAM_VALID_MASK_EN
    logic [(2**ADDR_W)-1:0] valid;
    logic                   miss;
`endif

    modport master (
        output operation, address, data_in,
`ifdef RAM_VALID_MASK_EN
        input  valid, miss,
`endif
        input  data_out, done
    );

    modport slave (
        input  operation, address, data_in,
`ifdef RAM_VALID_MASK_EN
        output valid, miss,
`endif
        output data_out, done
    );
endinterface

// File: rtl/module_ram_responder.sv
// Register-file RAM answering the CPU four-phase handshake with GET, SET and whole-array RESET.
// Optional feature macro RAM_VALID_MASK_EN adds a per-word written mask (valid) and a GET miss flag.
module module_ram_responder #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    module_ram_responder_if.slave   bus
);
    localparam int         DEPTH    = 2**ADDR_W;
    localparam logic [1:0] OP_IDLE  = 2'd0;
    localparam logic [1:0] OP_GET   = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_RESET = 2'd3;
    localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_CLEAR, S_DONE} state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [1:0]        op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] idx_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] data_out_r;
    logic [2:0]        cnt_r;
    logic              done_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic accept_s;
    logic start_clear_s;
    logic count_s;
    logic access_s;
    logic clear_wr_s;
    logic clear_last_s;
    logic release_s;

    // Next-state decode and one-cycle action strobes for the datapath
    always_comb begin
        next_state_s  = state_r;
        accept_s      = 1'b0;
        start_clear_s = 1'b0;
        count_s       = 1'b0;
        access_s      = 1'b0;
        clear_wr_s    = 1'b0;
        clear_last_s  = 1'b0;
        release_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if ((bus.operation == OP_GET) || (bus.operation == OP_SET)) begin
                    accept_s     = 1'b1;
                    next_state_s = S_BUSY;
                end else if (bus.operation == OP_RESET) begin
                    start_clear_s = 1'b1;
                    next_state_s  = S_CLEAR;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_BUSY: begin
                if (cnt_r != 3'd0) begin
                    count_s      = 1'b1;
                    next_state_s = S_BUSY;
                end else begin
                    access_s     = 1'b1;
                    next_state_s = S_DONE;
                end
            end
            S_CLEAR: begin
                clear_wr_s = 1'b1;
                if (idx_r == {ADDR_W{1'b1}}) begin
                    clear_last_s = 1'b1;
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_CLEAR;
                end
            end
            S_DONE: begin
                if (bus.operation == OP_IDLE) begin
                    release_s    = 1'b1;
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_DONE;
                end
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= S_IDLE;
        else        state_r <= next_state_s;
    end

    // Request latch, latency counter and clear index; inputs are frozen once accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r    <= OP_IDLE;
            addr_r  <= '0;
            wdata_r <= '0;
            cnt_r   <= 3'd0;
            idx_r   <= '0;
        end else begin
            if (accept_s) begin
                op_r    <= bus.operation;
                addr_r  <= bus.address;
                wdata_r <= bus.data_in;
                cnt_r   <= CNT_LOAD;
            end else if (count_s) begin
                cnt_r <= cnt_r - 3'd1;
            end
            if (start_clear_s) idx_r <= '0;
            else if (clear_wr_s) idx_r <= idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    // Storage array: one word cleared per cycle during RESET, single write on SET completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (clear_wr_s) begin
            mem_r[idx_r] <= '0;
        end else if (access_s && (op_r == OP_SET)) begin
            mem_r[addr_r] <= wdata_r;
        end
    end

    // Registered completion outputs; data_out moves only on GET completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_r <= '0;
            done_r     <= 1'b0;
        end else begin
            if (access_s && (op_r == OP_GET)) data_out_r <= mem_r[addr_r];
            if (access_s || clear_last_s) done_r <= 1'b1;
            else if (release_s)           done_r <= 1'b0;
        end
    end

    assign bus.data_out = data_out_r;
    assign bus.done     = done_r;

`ifdef RAM_VALID_MASK_EN
    logic [DEPTH-1:0] valid_r;
    logic             miss_r;

    // Written-word mask and miss flag, miss framed by the done pulse of a GET
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            miss_r  <= 1'b0;
        end else begin
            if (clear_last_s) valid_r <= '0;
            else if (access_s && (op_r == OP_SET)) valid_r[addr_r] <= 1'b1;
            if (access_s)       miss_r <= (op_r == OP_GET) ? ~valid_r[addr_r] : 1'b0;
            else if (release_s) miss_r <= 1'b0;
        end
    end

    assign bus.valid = valid_r;
    assign bus.miss  = miss_r;
`endif
endmodule

// File: tb/tb_module_ram_responder.sv
// Directed bench for module_ram_responder: reference memory model plus a GET-result scoreboard queue.
module tb_module_ram_responder;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;

    logic [15:0] mem_m [16];
    logic [15:0] last_out;
    logic [15:0] exp_q [$];
    logic [3:0]  ra;
    logic [15:0] rd;
`ifdef RAM_VALID_MASK_EN
    logic [15:0] valid_m;
`endif

    module_ram_responder_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    module_ram_responder #(.DATA_W(16), .ADDR_W(4), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mem_m[i] = 16'h0000;
`ifdef RAM_VALID_MASK_EN
        valid_m = 16'h0000;
`endif
    endtask

    // One full four-phase transaction with latency, result and hold checks
    task automatic req(input logic [1:0] op, input logic [3:0] a, input logic [15:0] d,
                       input int exp_lat, input int hold, input logic [1:0] hold_op,
                       input logic mid_chg, input logic [15:0] mid_d);
        int          n;
        logic [15:0] exp;
        @(negedge clk);
        bus.operation = op;
        bus.address   = a;
        bus.data_in   = d;
        if (op == 2'd1) exp_q.push_back(mem_m[a]);
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            if (mid_chg) begin
                bus.data_in = mid_d;
                bus.address = a ^ 4'hF;
            end
            @(posedge clk);
            #1;
            n++;
            if (!bus.done) check("data_out held while busy", bus.data_out, last_out);
        end while (!bus.done && (n < 40));
        check("done latency", n, exp_lat);
        case (op)
            2'd1: begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                check("get data", bus.data_out, exp);
                last_out = exp;
`ifdef RAM_VALID_MASK_EN
                check("get miss", bus.miss, ~valid_m[a]);
`endif
            end
            2'd2: begin
                check("data_out after set", bus.data_out, last_out);
                mem_m[a] = d;
`ifdef RAM_VALID_MASK_EN
                valid_m[a] = 1'b1;
`endif
            end
            2'd3: begin
                check("data_out after clear", bus.data_out, last_out);
                model_clear();
            end
            default: ;
        endcase
`ifdef RAM_VALID_MASK_EN
        check("valid mask", bus.valid, valid_m);
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            bus.operation = hold_op;
            @(posedge clk);
            #1;
            check("done held", bus.done, 1'b1);
        end
        @(negedge clk);
        bus.operation = 2'd0;
        @(posedge clk);
        #1;
        check("done released", bus.done, 1'b0);
`ifdef RAM_VALID_MASK_EN
        check("miss released", bus.miss, 1'b0);
`endif
    endtask

    task automatic get(input logic [3:0] a);
        req(2'd1, a, 16'h0000, LAT, 0, 2'd1, 1'b0, 16'h0000);
    endtask

    task automatic set(input logic [3:0] a, input logic [15:0] d);
        req(2'd2, a, d, LAT, 0, 2'd2, 1'b0, 16'h0000);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.operation = 2'd0;
        bus.address   = 4'h0;
        bus.data_in   = 16'h0000;
        last_out      = 16'h0000;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset done", bus.done, 1'b0);
        check("reset data_out", bus.data_out, 16'h0000);
`ifdef RAM_VALID_MASK_EN
        check("reset valid", bus.valid, 16'h0000);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        get(4'd5);
        set(4'd3, 16'hBEEF);
        get(4'd3);

        // SET held 6 cycles after done; data_in/address wiggle while busy
        req(2'd2, 4'd7, 16'hBEEF, LAT, 6, 2'd2, 1'b1, 16'h1234);
        get(4'd7);

        set(4'd0, 16'hAAAA);
        set(4'd15, 16'hAAAA);
        get(4'd15);
        req(2'd3, 4'd0, 16'h0000, 16, 2, 2'd1, 1'b0, 16'h0000);
        get(4'd0);
        get(4'd15);

        get(4'd9);
        set(4'd2, 16'h1111);
        get(4'd2);

        // rst_n asserted in the middle of a clear
        set(4'd12, 16'h7777);
        get(4'd12);
        @(negedge clk);
        bus.operation = 2'd3;
        @(posedge clk);
        repeat (8) @(posedge clk);
        #2;
        check("done low mid-clear", bus.done, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async reset done", bus.done, 1'b0);
        check("async reset data_out", bus.data_out, 16'h0000);
`ifdef RAM_VALID_MASK_EN
        check("async reset valid", bus.valid, 16'h0000);
`endif
        model_clear();
        last_out = 16'h0000;
        @(negedge clk);
        bus.operation = 2'd0;
        rst_n         = 1'b1;
        get(4'd12);
        get(4'd5);

        for (int i = 0; i < 10; i++) begin
            ra = 4'($urandom_range(15));
            rd = 16'($urandom);
            if ($urandom_range(1) == 1) set(ra, rd);
            else                        get(ra);
        end
        get(ra);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
